requant_int8: RTL and testbench
===============================

REQUANT_INT8 -- requirements
Module: requant_int8

Interface
REQ-001 SHALL have parameter ACC_W, default 32, signed accumulator input width.
REQ-002 SHALL have parameter MULT_W, default 16, unsigned per-layer scale multiplier width.
REQ-003 SHALL have parameter SHIFT_W, default 5, per-layer right-shift width.
REQ-004 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid_i  input  1  input beat valid.
REQ-007 SHALL have port in_ready_o  output  1  input beat accepted when in_valid_i and in_ready_o are both high.
REQ-008 SHALL have port in_acc_i  input  ACC_W  signed matmul accumulator.
REQ-009 SHALL have port layer_sel_i  input  2  layer index of the input beat.
REQ-010 SHALL have port cfg_we_i  input  1  scale-table write strobe.
REQ-011 SHALL have port cfg_layer_i  input  2  scale-table write index.
REQ-012 SHALL have port cfg_mult_i  input  MULT_W  unsigned multiplier to write.
REQ-013 SHALL have port cfg_shift_i  input  SHIFT_W  shift to write.
REQ-014 SHALL have port out_valid_o  output  1  output beat valid.
REQ-015 SHALL have port out_ready_i  input  1  downstream (GELU LUT stage) ready.
REQ-016 SHALL have port out_data_o  output  8  signed int8 result, fed to GELU in_data_i.
REQ-017 SHALL have port out_layer_o  output  2  layer index carried with the beat, fed to GELU layer_sel_i.

Function
REQ-018 SHALL compute out = sat8((acc*mult + R) >>> shift), where R = 2^(shift-1) if shift>0 else 0; mult zero-extended to signed; product and sum at least ACC_W+MULT_W+2 bits, never overflowing.
REQ-019 SHALL saturate to +127 (0x7F) above and -128 (0x80) below; arithmetic shift floors, so ties round toward +inf.
REQ-020 SHALL be a 2-stage pipeline: S1 registers the product, rounding constant, shift and layer; S2 registers round/shift/saturate result; out_valid_o rises 2 cycles after acceptance with out_ready_i held high.
REQ-021 SHALL use a global advance enable en = !out_valid_o || out_ready_i; in_ready_o = en; on !en both stages and all outputs hold.
REQ-022 SHALL propagate bubbles: an S1 slot with no accepted beat carries valid=0, and S2 shall drop it.
REQ-023 SHALL keep out_data_o and out_layer_o stable while out_valid_o is high and out_ready_i is low; beat order SHALL be preserved, with no loss or duplication.
REQ-024 SHALL hold a 4-entry scale table {mult, shift}, written on the rising edge when cfg_we_i is high, independent of en.
REQ-025 SHALL look up the table in S1 using the accepted beat's layer_sel_i; a write in the same cycle as acceptance to the same layer SHALL NOT affect that beat, and SHALL affect beats accepted on later cycles.
REQ-026 SHALL treat shift=0 as identity scaling (no rounding term); shift up to 2^SHIFT_W-1 SHALL be legal.

Reset
REQ-027 SHALL, while rst_ni is low, force out_valid_o=0, out_data_o=0, out_layer_o=0, clear both stage valids, and drive in_ready_o=1 on release.
REQ-028 SHALL reset every table entry to mult=1, shift=0.
REQ-029 SHALL discard beats in flight when reset is asserted mid-operation; none SHALL emerge after release.

Configuration
REQ-030 SHALL, with macro REQUANT_SAT_STATS_EN defined, add output sat_count_o (16 bits): it increments once per beat leaving S2 (out_valid_o & out_ready_i) whose result was clipped, sticks at 0xFFFF, and resets to 0.
REQ-031 SHALL, without REQUANT_SAT_STATS_EN, omit the sat_count_o port and its logic entirely; data behaviour SHALL be identical.

Verification
REQ-032 SHALL cover reset defaults: after release, acc=5 on layer 0 -> out 0x05, out_layer 0, 2 cycles after accept.
REQ-033 SHALL cover scaling and rounding: write layer 1 mult=3, shift=2; acc=7 -> 0x05; acc=-7 -> 0xFB (-5); acc=2 -> 0x02 (tie 1.5 rounds up).
REQ-034 SHALL cover saturation on layer 0 defaults: acc=1000 -> 0x7F; acc=-1000 -> 0x80; acc=-2^31 with mult=0xFFFF, shift=0 -> 0x80; with stats enabled, sat_count_o=3.
REQ-035 SHALL cover backpressure: out_ready_i low 5 cycles while 4 beats (acc 1,2,3,4) are offered -> in_ready_o low once S2 is full; all 4 beats delivered in order with stable data during stall.
REQ-036 SHALL cover same-cycle write/accept: accept acc=10 on layer 2 while writing layer 2 mult=2 -> 0x0A; next beat acc=10 -> 0x14.
REQ-037 SHALL cover reset mid-flight: rst_ni low with 2 beats in S1/S2 -> out_valid_o 0 immediately; no output after release; table back to mult=1, shift=0.

Source files
------------

// File: rtl/requant_int8.sv
// Requantises signed matmul accumulators to int8 via a per-layer {mult, shift} table.
// Optional macro REQUANT_SAT_STATS_EN adds a sticky 16-bit saturation counter output.
module requant_int8 #(
  parameter int ACC_W   = 32,
  parameter int MULT_W  = 16,
  parameter int SHIFT_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [ACC_W-1:0]   in_acc_i,
  input  logic [1:0]         layer_sel_i,
  input  logic               cfg_we_i,
  input  logic [1:0]         cfg_layer_i,
  input  logic [MULT_W-1:0]  cfg_mult_i,
  input  logic [SHIFT_W-1:0] cfg_shift_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [7:0]         out_data_o,
  output logic [1:0]         out_layer_o
`ifdef REQUANT_SAT_STATS_EN
  ,
  output logic [15:0]        sat_count_o
`endif
);

  // Wide enough that acc*mult plus the rounding constant can never overflow.
  localparam int SUM_W = ACC_W + MULT_W + 2;
  localparam logic [SUM_W-1:0] ONE = {{(SUM_W-1){1'b0}}, 1'b1};

  logic en;

  logic [MULT_W-1:0]  mult_q  [4];
  logic [SHIFT_W-1:0] shift_q [4];

  logic [MULT_W-1:0]        sel_mult;
  logic [SHIFT_W-1:0]       sel_shift;
  logic [SUM_W-1:0]         acc_ext;
  logic [SUM_W-1:0]         mult_ext;
  logic signed [SUM_W-1:0]  prod_d;
  logic signed [SUM_W-1:0]  rnd_d;

  logic                     s1_valid_q;
  logic signed [SUM_W-1:0]  s1_prod_q;
  logic signed [SUM_W-1:0]  s1_rnd_q;
  logic [SHIFT_W-1:0]       s1_shift_q;
  logic [1:0]               s1_layer_q;

  logic signed [SUM_W-1:0]  sum_d;
  logic signed [SUM_W-1:0]  shifted_d;
  logic [SUM_W-8:0]         hi_bits;
  logic                     clip_d;
  logic [7:0]               res_d;

  logic                     out_valid_q;
  logic [7:0]               out_data_q;
  logic [1:0]               out_layer_q;

  assign en          = !out_valid_q || out_ready_i;
  assign in_ready_o  = en;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_layer_o = out_layer_q;

  // Table writes ignore backpressure; reads see the pre-write value on the same edge.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_tbl
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          mult_q[gi]  <= MULT_W'(1);
          shift_q[gi] <= '0;
        end else if (cfg_we_i && (cfg_layer_i == 2'(gi))) begin
          mult_q[gi]  <= cfg_mult_i;
          shift_q[gi] <= cfg_shift_i;
        end
      end
    end
  endgenerate

  always_comb begin
    sel_mult  = mult_q[layer_sel_i];
    sel_shift = shift_q[layer_sel_i];
    acc_ext   = {{(SUM_W-ACC_W){in_acc_i[ACC_W-1]}}, in_acc_i};
    mult_ext  = {{(SUM_W-MULT_W){1'b0}}, sel_mult};
    prod_d    = $signed(acc_ext) * $signed(mult_ext);
    rnd_d     = (sel_shift != '0) ? $signed(ONE << (sel_shift - SHIFT_W'(1))) : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_prod_q  <= '0;
      s1_rnd_q   <= '0;
      s1_shift_q <= '0;
      s1_layer_q <= '0;
    end else if (en) begin
      s1_valid_q <= in_valid_i;
      if (in_valid_i) begin
        s1_prod_q  <= prod_d;
        s1_rnd_q   <= rnd_d;
        s1_shift_q <= sel_shift;
        s1_layer_q <= layer_sel_i;
      end
    end
  end

  // Result fits int8 only when every bit above bit 7 matches the sign.
  always_comb begin
    sum_d     = s1_prod_q + s1_rnd_q;
    shifted_d = sum_d >>> s1_shift_q;
    hi_bits   = shifted_d[SUM_W-1:7];
    clip_d    = !((&hi_bits) || !(|hi_bits));
    if (clip_d) begin
      res_d = shifted_d[SUM_W-1] ? 8'h80 : 8'h7F;
    end else begin
      res_d = shifted_d[7:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_layer_q <= '0;
    end else if (en) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q  <= res_d;
        out_layer_q <= s1_layer_q;
      end
    end
  end

`ifdef REQUANT_SAT_STATS_EN
  logic        out_sat_q;
  logic [15:0] sat_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_sat_q <= 1'b0;
    end else if (en && s1_valid_q) begin
      out_sat_q <= clip_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sat_cnt_q <= '0;
    end else if (out_valid_q && out_ready_i && out_sat_q && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end

  assign sat_count_o = sat_cnt_q;
`endif

endmodule

// File: tb/tb_requant_int8.sv
// Directed self-checking bench for requant_int8 (exercises sat_count_o when
// REQUANT_SAT_STATS_EN is defined).
module tb_requant_int8;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_acc_i;
  logic [1:0]  layer_sel_i;
  logic        cfg_we_i;
  logic [1:0]  cfg_layer_i;
  logic [15:0] cfg_mult_i;
  logic [4:0]  cfg_shift_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [7:0]  out_data_o;
  logic [1:0]  out_layer_o;
`ifdef REQUANT_SAT_STATS_EN
  logic [15:0] sat_count_o;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [9:0] mon_q[$];

  always #5 clk_i = ~clk_i;

  requant_int8 dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_acc_i    (in_acc_i),
    .layer_sel_i (layer_sel_i),
    .cfg_we_i    (cfg_we_i),
    .cfg_layer_i (cfg_layer_i),
    .cfg_mult_i  (cfg_mult_i),
    .cfg_shift_i (cfg_shift_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_layer_o (out_layer_o)
`ifdef REQUANT_SAT_STATS_EN
    ,
    .sat_count_o (sat_count_o)
`endif
  );

  // Record every beat that will transfer on the coming rising edge.
  always @(negedge clk_i) begin
    if (rst_ni && out_valid_o && out_ready_i) mon_q.push_back({out_layer_o, out_data_o});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic cfg(input logic [1:0] layer, input logic [15:0] mult, input logic [4:0] shift);
    cfg_we_i = 1'b1; cfg_layer_i = layer; cfg_mult_i = mult; cfg_shift_i = shift;
    @(posedge clk_i); #1;
    cfg_we_i = 1'b0;
  endtask

  task automatic send(input logic [31:0] acc, input logic [1:0] layer);
    int t;
    t = 0;
    in_valid_i = 1'b1; in_acc_i = acc; layer_sel_i = layer;
    @(negedge clk_i);
    while (!in_ready_o && t < 50) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= 50) check("send_ready_timeout", 32'(in_ready_o), 32'd1);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] d, input logic [1:0] l);
    logic [9:0] e;
    int t;
    t = 0;
    while (mon_q.size() == 0 && t < 30) begin
      @(posedge clk_i); #1;
      t++;
    end
    check({tag, "_avail"}, 32'(mon_q.size() != 0), 32'd1);
    if (mon_q.size() != 0) begin
      e = mon_q.pop_front();
      check({tag, "_data"}, 32'(e[7:0]), 32'(d));
      check({tag, "_layer"}, 32'(e[9:8]), 32'(l));
    end
  endtask

  initial begin
    rst_ni = 1'b0; in_valid_i = 1'b0; in_acc_i = '0; layer_sel_i = '0;
    cfg_we_i = 1'b0; cfg_layer_i = '0; cfg_mult_i = '0; cfg_shift_i = '0;
    out_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_valid", 32'(out_valid_o), 32'd0);
    check("rst_data", 32'(out_data_o), 32'd0);
    check("rst_layer", 32'(out_layer_o), 32'd0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check("rst_inrdy", 32'(in_ready_o), 32'd1);

    // Reset defaults and two-cycle latency
    send(32'd5, 2'd0);
    check("lat_s1", 32'(out_valid_o), 32'd0);
    @(posedge clk_i); #1;
    check("lat_s2", 32'(out_valid_o), 32'd1);
    check("lat_data", 32'(out_data_o), 32'h05);
    expect_out("dflt5", 8'h05, 2'd0);

    // Scaling and rounding: mult=3 shift=2
    cfg(2'd1, 16'd3, 5'd2);
    send(32'd7, 2'd1);
    send(-32'sd7, 2'd1);
    send(32'd2, 2'd1);
    send(-32'sd2, 2'd1);
    expect_out("rnd_p7", 8'h05, 2'd1);
    expect_out("rnd_m7", 8'hFB, 2'd1);
    expect_out("tie_p2", 8'h02, 2'd1);
    expect_out("tie_m2", 8'hFF, 2'd1);

    // Saturation
    cfg(2'd3, 16'hFFFF, 5'd0);
    send(32'd1000, 2'd0);
    send(-32'sd1000, 2'd0);
    send(32'h8000_0000, 2'd3);
    expect_out("sat_hi", 8'h7F, 2'd0);
    expect_out("sat_lo", 8'h80, 2'd0);
    expect_out("sat_min", 8'h80, 2'd3);
    repeat (2) @(posedge clk_i);
    #1;
`ifdef REQUANT_SAT_STATS_EN
    check("sat_count", 32'(sat_count_o), 32'd3);
`endif

    // Maximum shift: 2^30 * 1 + 2^30 >> 31 = 1
    cfg(2'd3, 16'd1, 5'd31);
    send(32'h4000_0000, 2'd3);
    expect_out("shift31", 8'h01, 2'd3);

    // Backpressure: ready low for 5 cycles while four beats are offered
    out_ready_i = 1'b0;
    fork
      begin
        for (int i = 1; i <= 4; i++) send(32'(i), 2'd0);
      end
    join_none
    repeat (5) begin
      @(posedge clk_i); #1;
      if (out_valid_o) check("bp_stable", 32'(out_data_o), 32'h01);
    end
    check("bp_inrdy", 32'(in_ready_o), 32'd0);
    check("bp_valid", 32'(out_valid_o), 32'd1);
    out_ready_i = 1'b1;
    wait fork;
    for (int i = 1; i <= 4; i++) expect_out("bp_order", 8'(i), 2'd0);

    // Same-cycle write and accept on layer 2
    cfg_we_i = 1'b1; cfg_layer_i = 2'd2; cfg_mult_i = 16'd2; cfg_shift_i = 5'd0;
    in_valid_i = 1'b1; in_acc_i = 32'd10; layer_sel_i = 2'd2;
    @(negedge clk_i);
    check("wr_acc_rdy", 32'(in_ready_o), 32'd1);
    @(posedge clk_i); #1;
    cfg_we_i = 1'b0; in_valid_i = 1'b0;
    send(32'd10, 2'd2);
    expect_out("wr_same", 8'h0A, 2'd2);
    expect_out("wr_next", 8'h14, 2'd2);

    // Reset with beats in both stages
    send(32'd20, 2'd0);
    send(32'd30, 2'd0);
    check("mid_inflight", 32'(out_valid_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    check("mid_valid", 32'(out_valid_o), 32'd0);
    check("mid_data", 32'(out_data_o), 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    repeat (6) @(posedge clk_i);
    #1;
    check("mid_no_out", 32'(mon_q.size()), 32'd0);
    send(32'd7, 2'd1);
    send(32'd10, 2'd2);
    expect_out("mid_tbl1", 8'h07, 2'd1);
    expect_out("mid_tbl2", 8'h0A, 2'd2);
`ifdef REQUANT_SAT_STATS_EN
    check("mid_satcnt", 32'(sat_count_o), 32'd0);
`endif

    repeat (4) @(posedge clk_i);
    #1;
    check("no_extra", 32'(mon_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
